// File: rtl/gate_bist_if.sv
// Signal bundle between the lab control side / gate under test and gate_bist_ctrl.
// master: lab side plus gate model; slave: the BIST controller.
`timescale 1ns/1ps
interface gate_bist_if;
  logic       start;
  logic       dut_y;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] pass_count;
  logic [2:0] fail_count;
  logic [3:0] fail_mask;

  modport master (
    output start, dut_y,
    input  dut_a, dut_b, busy, done, pass, pass_count, fail_count, fail_mask
  );

  modport slave (
    input  start, dut_y,
    output dut_a, dut_b, busy, done, pass, pass_count, fail_count, fail_mask
  );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Exhaustive BIST sequencer for one 2-input combinational gate.
// Optional macro GATE_BIST_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
//
// state  | meaning
// IDLE   | waiting for start, results of the last run held
// SETTLE | current vector driven, settle down-counter running
// SAMPLE | compare dut_y against EXPECTED[idx], update results
// REPORT | done pulse, pass flag valid
`timescale 1ns/1ps
module gate_bist_ctrl #(
  parameter logic [3:0]  EXPECTED      = 4'b0001,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  gate_bist_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic [2:0] pass_count, fail_count, fail_count_nxt;
  logic [3:0] fail_mask;
  logic       pass;
  logic       load_run, sample_en, advance, enter_report;
  logic       mismatch, stop_hit;

  assign mismatch       = (bus.dut_y != EXPECTED[idx]);
  assign fail_count_nxt = fail_count + {2'b00, mismatch};

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_run     = 1'b0;
    sample_en    = 1'b0;
    advance      = 1'b0;
    enter_report = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load_run  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 8'd1) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        sample_en = 1'b1;
        if (idx == 2'd3 || stop_hit) begin
          enter_report = 1'b1;
          state_nxt    = REPORT;
        end else begin
          advance   = 1'b1;
          state_nxt = SETTLE;
        end
      end
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Settle timer: loaded per vector, terminal count of 1 ends SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= 8'd0;
    else if (load_run || advance) cnt <= SETTLE_LOAD;
    else if (state == SETTLE)     cnt <= cnt - 8'd1;
  end

  // The vector index is the applied vector itself, so it holds 11 after a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        idx <= 2'd0;
    else if (load_run) idx <= 2'd0;
    else if (advance)  idx <= idx + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_count <= 3'd0;
      fail_count <= 3'd0;
      fail_mask  <= 4'd0;
      pass       <= 1'b0;
    end else if (load_run) begin
      pass_count <= 3'd0;
      fail_count <= 3'd0;
      fail_mask  <= 4'd0;
      pass       <= 1'b0;
    end else if (sample_en) begin
      fail_count <= fail_count_nxt;
      if (mismatch) fail_mask[idx] <= 1'b1;
      else          pass_count     <= pass_count + 3'd1;
      if (enter_report) pass <= (fail_count_nxt == 3'd0);
    end
  end

  assign bus.dut_a      = idx[1];
  assign bus.dut_b      = idx[0];
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == REPORT);
  assign bus.pass       = pass;
  assign bus.pass_count = pass_count;
  assign bus.fail_count = fail_count;
  assign bus.fail_mask  = fail_mask;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: fixed gate table, restart/reset sequences, random gates vs. a reference model.
`timescale 1ns/1ps
module tb_gate_bist_ctrl;

  localparam logic [3:0] EXPV = 4'b0001;
  localparam int         S    = 2;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    logic [3:0] tt;
    logic       exp_pass;
    int         pc;
    int         fc;
    logic [3:0] mask;
    int         done_c;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] gate_tt = 4'b0001;
  int         n_checks = 0;
  int         n_fail   = 0;
  vec_t       tbl [6];

  gate_bist_if bus ();

  gate_bist_ctrl #(.EXPECTED(EXPV), .SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Gate under test: truth table indexed by {a,b}.
  assign bus.dut_y = gate_tt[{bus.dut_a, bus.dut_b}];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ctl();
    return {bus.busy, bus.done, bus.dut_a, bus.dut_b};
  endfunction

  function automatic logic [10:0] res();
    return {bus.pass, bus.pass_count, bus.fail_count, bus.fail_mask};
  endfunction

  // Reference: walk vectors 0..3 in order, score each against the expected table.
  task automatic model(input logic [3:0] tt, output logic p, output int pc, output int fc,
                       output logic [3:0] mask, output int dc);
    logic [3:0] exp_tt;
    int         n;
    exp_tt = EXPV;
    pc = 0; fc = 0; mask = 4'd0; n = 0;
    for (int k = 0; k < 4; k++) begin
      n++;
      if (tt[k] == exp_tt[k]) pc++;
      else begin
        fc++;
        mask[k] = 1'b1;
        if (STOP) break;
      end
    end
    p  = (fc == 0);
    dc = n * (S + 1) + 1;
  endtask

  // Called just after a rising edge. Cycle c lies between edge c-1 and edge c; edge 0 accepts start.
  task automatic run_check(input string tag, input logic [3:0] tt, input logic ep, input int epc,
                           input int efc, input logic [3:0] emask, input int edone,
                           input int p1, input int p2, input bit started, input bit chain);
    int         last, vi;
    logic [3:0] exp_ctl;
    logic [10:0] exp_res;
    gate_tt = tt;
    last    = (edone - 1) / (S + 1) - 1;
    exp_res = {ep, 3'(epc), 3'(efc), emask};
    if (!started) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
    end
    for (int c = 1; c <= edone + 1; c++) begin
      bus.start = (c == p1) || (c == p2) || (chain && c == edone + 1);
      @(negedge clk);
      vi = (c - 1) / (S + 1);
      if (vi > last) vi = last;
      exp_ctl = {(c <= edone), (c == edone), 2'(vi)};
      check($sformatf("%s ctl c%0d", tag, c), int'(ctl()), int'(exp_ctl));
      if (c == 1)
        check($sformatf("%s cleared c1", tag), int'(res()), 0);
      if (c >= edone)
        check($sformatf("%s result c%0d", tag, c), int'(res()), int'(exp_res));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] tt, mask;
    logic       p;
    int         pc, fc, dc, p1, p2;
    bit         chain, prev_chain;

    if (!STOP) begin
      tbl[0] = '{4'b0001, 1'b1, 4, 0, 4'b0000, 13};
      tbl[1] = '{4'b0000, 1'b0, 3, 1, 4'b0001, 13};
      tbl[2] = '{4'b1000, 1'b0, 2, 2, 4'b1001, 13};
      tbl[3] = '{4'b0110, 1'b0, 1, 3, 4'b0111, 13};
      tbl[4] = '{4'b1111, 1'b0, 1, 3, 4'b1110, 13};
      tbl[5] = '{4'b0111, 1'b0, 2, 2, 4'b0110, 13};
    end else begin
      tbl[0] = '{4'b0001, 1'b1, 4, 0, 4'b0000, 13};
      tbl[1] = '{4'b0000, 1'b0, 0, 1, 4'b0001, 4};
      tbl[2] = '{4'b1000, 1'b0, 0, 1, 4'b0001, 4};
      tbl[3] = '{4'b0110, 1'b0, 0, 1, 4'b0001, 4};
      tbl[4] = '{4'b1111, 1'b0, 1, 1, 4'b0010, 7};
      tbl[5] = '{4'b0111, 1'b0, 1, 1, 4'b0010, 7};
    end

    bus.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset ctl", int'(ctl()), 0);
    check("reset results", int'(res()), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_check($sformatf("table%0d", i), tbl[i].tt, tbl[i].exp_pass, tbl[i].pc, tbl[i].fc,
                tbl[i].mask, tbl[i].done_c, 0, 0, 1'b0, 1'b0);

    // start pulses while busy are ignored; a start in the idle cycle after done restarts
    run_check("ignore", tbl[0].tt, tbl[0].exp_pass, tbl[0].pc, tbl[0].fc, tbl[0].mask,
              tbl[0].done_c, 4, 12, 1'b0, 1'b1);
    run_check("restart", tbl[1].tt, tbl[1].exp_pass, tbl[1].pc, tbl[1].fc, tbl[1].mask,
              tbl[1].done_c, 0, 0, 1'b1, 1'b0);

    // reset asserted mid-cycle 6 of a run
    gate_tt   = 4'b0001;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst ctl", int'(ctl()), 0);
    check("midrst results", int'(res()), 0);
    @(negedge clk);
    check("midrst held ctl", int'(ctl()), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("after reset idle", int'(ctl()), 0);
    @(posedge clk); #1;
    run_check("post_reset", tbl[0].tt, tbl[0].exp_pass, tbl[0].pc, tbl[0].fc, tbl[0].mask,
              tbl[0].done_c, 0, 0, 1'b0, 1'b0);

    prev_chain = 1'b0;
    for (int r = 0; r < 12; r++) begin
      tt = 4'($urandom_range(0, 15));
      model(tt, p, pc, fc, mask, dc);
      p1    = $urandom_range(1, dc);
      p2    = $urandom_range(1, dc);
      chain = ($urandom_range(0, 1) == 1);
      run_check($sformatf("rand%0d_tt%b", r, tt), tt, p, pc, fc, mask, dc, p1, p2, prev_chain, chain);
      prev_chain = chain;
    end
    if (prev_chain) begin
      model(4'b0001, p, pc, fc, mask, dc);
      run_check("flush", 4'b0001, p, pc, fc, mask, dc, 0, 0, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test sequencer for a single 2-input combinational gate. On a start request it drives all four input vectors onto the gate under test and waits a programmable settle time after each. It then samples the gate output and compares it against a parameterised truth table, reporting per-vector failures, pass/fail counts and a one-cycle completion pulse. It sits between the lab control logic and any 2-input gate block (NOR, NAND, XOR, …) so one controller can exercise whichever gate is instantiated.

## Interface
- `EXPECTED`, default 4'b0001: expected output truth table; bit `i` is the expected `dut_y` for vector `{dut_a,dut_b} = i`. The default is NOR.
- `SETTLE_CYCLES`, default 2: cycles a vector is held before sampling; legal range 1..255.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a test run; sampled only in IDLE.
- `dut_y`  in  1  output of the gate under test.
- `dut_a`  out  1  registered gate input a (vector MSB).
- `dut_b`  out  1  registered gate input b (vector LSB).
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse when results are valid.
- `pass`  out  1  high if the last completed run had zero mismatches.
- `pass_count`  out  3  vectors matched in the last run, 0..4.
- `fail_count`  out  3  vectors mismatched in the last run, 0..4.
- `fail_mask`  out  4  bit `i` set if vector `i` mismatched.

## Operation
The controller is a state machine with four states: IDLE, SETTLE, SAMPLE and REPORT.

- **IDLE**
  - `busy`=0.
  - On `start`=1, on the same edge:
    - clear `pass_count`, `fail_count`, `fail_mask` and `pass`;
    - set vector index to 0 and drive `{dut_a,dut_b}`=00;
    - load the settle counter with `SETTLE_CYCLES`;
    - go to SETTLE.
- **SETTLE**
  - Decrement the counter each cycle.
  - When the counter equals 1, go to SAMPLE.
  - Total time in SETTLE is exactly `SETTLE_CYCLES` cycles.
- **SAMPLE** (one cycle)
  - Compare `dut_y` against `EXPECTED[idx]`.
  - On a match, increment `pass_count`. On a mismatch, increment `fail_count` and set `fail_mask[idx]`.
  - If `idx`==3, go to REPORT.
  - Otherwise, increment `idx`, drive the next vector, reload the counter and go to SETTLE.
- **REPORT** (one cycle)
  - `done`=1.
  - `pass` = (final `fail_count`==0), registered on entry.
  - Go to IDLE.

Other rules:
- `busy`=1 in SETTLE, SAMPLE and REPORT.
- `start` is ignored while `busy`=1.
- Results (`pass`, counts, `fail_mask`) hold from REPORT until the next accepted `start`.
- `dut_a`/`dut_b` keep the last vector (11) after a full run; they return to 00 only on reset or when the next run starts.
- Vector order is fixed: 00, 01, 10, 11.
- Invariant: `pass_count + fail_count` = number of vectors sampled, never above 4.
- The counters are 3 bits wide and cannot overflow.

## Timing
- **Reset** (asynchronous, immediate on `rst_n`=0):
  - state IDLE;
  - `dut_a`=`dut_b`=0, `busy`=0, `done`=0, `pass`=0;
  - `pass_count`=`fail_count`=0, `fail_mask`=0;
  - internal index and counter = 0.
- **Reset mid-run:** the run is abandoned, no `done` pulse, all outputs go to reset values. The first `start` after `rst_n` deasserts runs a full test.
- **Cycle numbering:** edge 0 is the edge on which `start` is accepted.
  - Vector `k` is driven from edge `k·(S+1)`.
  - Vector `k` is sampled at the end of cycle `k·(S+1)+S+1`.
  - `done` is high during cycle `4·(S+1)+1`, i.e. cycle 13 for S=2.
- **Restart:** earliest next `start` acceptance is the cycle after `done` (IDLE). A `start` held high continuously therefore restarts on that cycle.
- **Sampling:** `dut_y` is sampled synchronously. The gate path must settle within `SETTLE_CYCLES` clock periods.

## Configuration
- Macro `GATE_BIST_STOP_ON_FAIL_EN`.
- **Defined:** a mismatch in SAMPLE goes directly to REPORT after updating the counts and mask. Remaining vectors are not applied, `pass`=0, and `done` is high in the cycle after the failing SAMPLE.
- **Undefined:** all four vectors are always applied regardless of mismatches. This is the default.

## Test plan
1. Correct NOR model, default parameters, `start` pulse:
   - `{dut_a,dut_b}` steps 00→01→10→11 at edges 0, 3, 6, 9;
   - `done` high only in cycle 13;
   - `pass`=1, `pass_count`=4, `fail_count`=0, `fail_mask`=0000.
2. `dut_y` stuck at 0, default parameters:
   - `done` in cycle 13;
   - `pass`=0, `pass_count`=3, `fail_count`=1, `fail_mask`=0001.
3. AND model with `EXPECTED`=0001:
   - `fail_mask`=1001, `pass_count`=2, `fail_count`=2, `pass`=0.
4. `start` pulsed again in cycles 4 and 12:
   - both ignored; `done` still in cycle 13, single run.
   - Second `start` in cycle 14 clears the results in cycle 15 and completes at relative cycle 13.
5. `rst_n` low in cycle 6 of a run:
   - all outputs zero immediately, no `done`;
   - a fresh `start` afterwards gives a full 4-vector result matching scenario 1.
6. With `GATE_BIST_STOP_ON_FAIL_EN`, `dut_y` stuck at 0:
   - `done` in cycle 4;
   - `fail_mask`=0001, `fail_count`=1, `pass_count`=0, `pass`=0;
   - `{dut_a,dut_b}` never leaves 00.
